// File: rtl/cv32e40x_div_param_if.sv
// rtl/cv32e40x_div_param_if.sv - opcode package and request/response interface for the divider
// Package cv32e40x_div_param_pkg: div_opcode_e (DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU).
// Interface cv32e40x_div_param_if #(WIDTH):
//   operator_i, data_ind_timing_i, op_a_i, op_b_i, valid_i, halt_i, ready_i : requester -> divider
//   ready_o, valid_o, result_o                                            : divider -> requester
//   modport master = requester side, modport slave = divider side.

package cv32e40x_div_param_pkg;
    typedef enum logic [1:0] {
        DIV_DIV  = 2'b00,
        DIV_DIVU = 2'b01,
        DIV_REM  = 2'b10,
        DIV_REMU = 2'b11
    } div_opcode_e;
endpackage

interface cv32e40x_div_param_if #(
    parameter int WIDTH = 32
) ();
    import cv32e40x_div_param_pkg::*;

    div_opcode_e      operator_i;
    logic             data_ind_timing_i;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic             valid_i;
    logic             halt_i;
    logic             ready_o;
    logic             ready_i;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output operator_i, data_ind_timing_i, op_a_i, op_b_i, valid_i, halt_i, ready_i,
        input  ready_o, valid_o, result_o
    );

    modport slave (
        input  operator_i, data_ind_timing_i, op_a_i, op_b_i, valid_i, halt_i, ready_i,
        output ready_o, valid_o, result_o
    );
endinterface

// File: rtl/cv32e40x_div_param.sv
// rtl/cv32e40x_div_param.sv - iterative shift-subtract divider with optional result reuse cache
// Ports: clk, rst (async, active-high), bus (cv32e40x_div_param_if.slave).
// Parameters: WIDTH (even, >= 4), REUSE_EN (quotient/remainder reuse cache enable).
// The datapath works on magnitudes; signs are applied on the way out.

module cv32e40x_div_param
    import cv32e40x_div_param_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit REUSE_EN = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    cv32e40x_div_param_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, DIVIDE, DUMMY, FINISH} state_e;

    state_e           state;
    logic [WIDTH-1:0] rem_q, div_q, quo_q, op_a_q, op_b_q;
    logic [CW-1:0]    cnt_q, s_q;
    logic             signed_q, rem_sel_q, a_neg_q, q_neg_q, dit_q, hit_q;

    logic             reuse_valid_q, reuse_signed_q;
    logic [WIDTH-1:0] reuse_a_q, reuse_b_q, reuse_quo_q, reuse_rem_q;

    logic             in_signed, in_rem, a_neg, b_neg, b_zero, kill, hit, ge;
    logic [WIDTH-1:0] a_abs, b_abs, quo_res, rem_res;
    logic [CW-1:0]    lz;

    assign in_signed = (bus.operator_i == DIV_DIV) || (bus.operator_i == DIV_REM);
    assign in_rem    = (bus.operator_i == DIV_REM) || (bus.operator_i == DIV_REMU);
    assign a_neg     = in_signed && bus.op_a_i[WIDTH-1];
    assign b_neg     = in_signed && bus.op_b_i[WIDTH-1];
    // Negating MIN wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign a_abs     = a_neg ? -bus.op_a_i : bus.op_a_i;
    assign b_abs     = b_neg ? -bus.op_b_i : bus.op_b_i;
    assign b_zero    = (bus.op_b_i == '0);
    assign kill      = !bus.valid_i && !bus.halt_i;
    assign ge        = (rem_q >= div_q);

    assign hit = REUSE_EN && reuse_valid_q && !bus.data_ind_timing_i &&
                 (reuse_a_q == bus.op_a_i) && (reuse_b_q == bus.op_b_i) &&
                 (reuse_signed_q == in_signed);

    // Leading-zero count of |b|; the highest set bit wins because it is visited last.
    always_comb begin
        lz = CW'(WIDTH - 1);
        for (int i = 0; i < WIDTH; i++) begin
            if (b_abs[i]) begin
                lz = CW'(WIDTH - 1 - i);
            end
        end
    end

    assign quo_res = hit_q ? reuse_quo_q : (q_neg_q ? -quo_q : quo_q);
    assign rem_res = hit_q ? reuse_rem_q : (a_neg_q ? -rem_q : rem_q);

    assign bus.valid_o  = (state == FINISH) && !kill;
    assign bus.ready_o  = !rst && (kill || ((state == FINISH) && bus.ready_i && !bus.halt_i));
    assign bus.result_o = (state == FINISH) ? (rem_sel_q ? rem_res : quo_res) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            rem_q          <= '0;
            div_q          <= '0;
            quo_q          <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            cnt_q          <= '0;
            s_q            <= '0;
            signed_q       <= 1'b0;
            rem_sel_q      <= 1'b0;
            a_neg_q        <= 1'b0;
            q_neg_q        <= 1'b0;
            dit_q          <= 1'b0;
            hit_q          <= 1'b0;
            reuse_valid_q  <= 1'b0;
            reuse_signed_q <= 1'b0;
            reuse_a_q      <= '0;
            reuse_b_q      <= '0;
            reuse_quo_q    <= '0;
            reuse_rem_q    <= '0;
        end else if (!bus.halt_i) begin
            if (kill) begin
                state <= IDLE;
                if (state != FINISH) begin
                    reuse_valid_q <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        op_a_q    <= bus.op_a_i;
                        op_b_q    <= bus.op_b_i;
                        signed_q  <= in_signed;
                        rem_sel_q <= in_rem;
                        a_neg_q   <= a_neg;
                        q_neg_q   <= (a_neg ^ b_neg) && !b_zero;
                        dit_q     <= bus.data_ind_timing_i;
                        s_q       <= lz;
                        hit_q     <= hit;
                        quo_q     <= b_zero ? '1 : '0;
                        rem_q     <= a_abs;
                        div_q     <= b_abs << lz;
                        if (hit) begin
                            state <= FINISH;
                        end else if (b_zero) begin
                            // Zero divisor in constant-time mode pads to the full WIDTH+1 latency.
                            if (bus.data_ind_timing_i) begin
                                state <= DUMMY;
                                cnt_q <= CW'(WIDTH - 1);
                            end else begin
                                state <= FINISH;
                            end
                        end else begin
                            state <= DIVIDE;
                            cnt_q <= lz;
                        end
                    end
                    DIVIDE: begin
                        if (ge) begin
                            rem_q <= rem_q - div_q;
                        end
                        quo_q <= {quo_q[WIDTH-2:0], ge};
                        div_q <= div_q >> 1;
                        if (cnt_q == '0) begin
                            if (dit_q && (s_q != CW'(WIDTH - 1))) begin
                                state <= DUMMY;
                                cnt_q <= CW'(WIDTH - 2) - s_q;
                            end else begin
                                state <= FINISH;
                            end
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    DUMMY: begin
                        if (cnt_q == '0) begin
                            state <= FINISH;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    FINISH: begin
                        if (bus.ready_i) begin
                            state <= IDLE;
                            if (REUSE_EN) begin
                                reuse_valid_q  <= 1'b1;
                                reuse_signed_q <= signed_q;
                                reuse_a_q      <= op_a_q;
                                reuse_b_q      <= op_b_q;
                                reuse_quo_q    <= quo_res;
                                reuse_rem_q    <= rem_res;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cv32e40x_div_param.sv
// tb/tb_cv32e40x_div_param.sv - directed table-driven bench for cv32e40x_div_param

module tb_cv32e40x_div_param;
    import cv32e40x_div_param_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cv32e40x_div_param_if #(.WIDTH(32)) bus ();

    cv32e40x_div_param #(.WIDTH(32), .REUSE_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        div_opcode_e op;
        logic        dit;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string what, input int tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s tag=%0d actual=%h required=%h", what, tag, act, req);
        end
    endtask

    // Called on a falling edge; that cycle is cycle 0 (the accept cycle).
    task automatic run_op(input div_opcode_e op, input logic dit, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat, input int tag);
        int   n;
        logic early;
        bus.operator_i        = op;
        bus.data_ind_timing_i = dit;
        bus.op_a_i            = a;
        bus.op_b_i            = b;
        bus.valid_i           = 1'b1;
        bus.halt_i            = 1'b0;
        bus.ready_i           = 1'b1;
        n     = 0;
        early = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (!bus.valid_o && bus.ready_o) early = 1'b1;
        end while (!bus.valid_o && n < 100);
        check("latency", tag, n, lat);
        check("result", tag, bus.result_o, exp);
        check("ready_at_finish", tag, {31'd0, bus.ready_o}, 32'd1);
        check("busy_ready", tag, {31'd0, early}, 32'd0);
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.halt_i  = 1'b1;
        check("valid_after_handshake", tag, {31'd0, bus.valid_o}, 32'd0);
    endtask

    initial begin
        int n;
        logic bad;
        checks   = 0;
        failures = 0;

        vecs[0]  = '{DIV_DIV,  1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32};
        vecs[1]  = '{DIV_REM,  1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1};
        vecs[2]  = '{DIV_DIVU, 1'b0, 32'd100,      32'd0,        32'hFFFFFFFF, 1};
        vecs[3]  = '{DIV_REM,  1'b0, 32'h80000000, 32'd0,        32'h80000000, 1};
        vecs[4]  = '{DIV_DIV,  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
        vecs[5]  = '{DIV_REM,  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        vecs[6]  = '{DIV_DIVU, 1'b1, 32'hFFFFFFFF, 32'h80000000, 32'd1,        33};
        vecs[7]  = '{DIV_DIVU, 1'b1, 32'd5,        32'd1,        32'd5,        33};
        vecs[8]  = '{DIV_DIV,  1'b0, 32'd100,      32'd7,        32'd14,       31};
        vecs[9]  = '{DIV_REM,  1'b0, 32'd100,      32'd7,        32'd2,        1};
        vecs[10] = '{DIV_REM,  1'b1, 32'd100,      32'd7,        32'd2,        33};
        vecs[11] = '{DIV_DIV,  1'b0, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 31};
        vecs[12] = '{DIV_REM,  1'b0, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 1};
        vecs[13] = '{DIV_REM,  1'b0, 32'd100,      32'hFFFFFFF9, 32'd2,        31};
        vecs[14] = '{DIV_DIV,  1'b0, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1};
        vecs[15] = '{DIV_DIVU, 1'b0, 32'd100,      32'hFFFFFFF9, 32'd0,        2};
        vecs[16] = '{DIV_DIVU, 1'b1, 32'd0,        32'd0,        32'hFFFFFFFF, 33};
        vecs[17] = '{DIV_REMU, 1'b0, 32'd7,        32'd0,        32'd7,        1};

        // Reset state, with the request lines in the kill pattern.
        rst                   = 1'b1;
        bus.operator_i        = DIV_DIV;
        bus.data_ind_timing_i = 1'b0;
        bus.op_a_i            = 32'd0;
        bus.op_b_i            = 32'd0;
        bus.valid_i           = 1'b0;
        bus.halt_i            = 1'b0;
        bus.ready_i           = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 0, {31'd0, bus.valid_o}, 32'd0);
        check("rst_ready", 0, {31'd0, bus.ready_o}, 32'd0);
        check("rst_result", 0, bus.result_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_kill_ready", 0, {31'd0, bus.ready_o}, 32'd1);
        bus.halt_i = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].op, vecs[i].dit, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, i);
        end

        // Kill in DIVIDE invalidates the cached 100/7 entry.
        run_op(DIV_DIV, 1'b0, 32'd100, 32'd7, 32'd14, 31, 100);
        bus.operator_i        = DIV_DIV;
        bus.data_ind_timing_i = 1'b1;
        bus.op_a_i            = 32'd100;
        bus.op_b_i            = 32'd7;
        bus.valid_i           = 1'b1;
        bus.halt_i            = 1'b0;
        repeat (5) @(negedge clk);
        bus.valid_i = 1'b0;
        #1;
        check("kill_ready", 101, {31'd0, bus.ready_o}, 32'd1);
        check("kill_valid", 101, {31'd0, bus.valid_o}, 32'd0);
        @(negedge clk);
        check("post_kill_valid", 101, {31'd0, bus.valid_o}, 32'd0);
        bus.halt_i = 1'b1;
        @(negedge clk);
        run_op(DIV_REM, 1'b0, 32'd100, 32'd7, 32'd2, 31, 102);

        // Halt with valid_i low freezes a division mid-flight.
        bus.operator_i        = DIV_DIV;
        bus.data_ind_timing_i = 1'b0;
        bus.op_a_i            = 32'hFFFFFFF9;
        bus.op_b_i            = 32'd2;
        bus.valid_i           = 1'b1;
        bus.halt_i            = 1'b0;
        repeat (10) @(negedge clk);
        bus.valid_i = 1'b0;
        bus.halt_i  = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.valid_o || bus.ready_o) bad = 1'b1;
        end
        check("halt_frozen_outputs", 103, {31'd0, bad}, 32'd0);
        bus.valid_i = 1'b1;
        bus.halt_i  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.valid_o && n < 100);
        check("halt_remaining_cycles", 103, n, 22);
        check("halt_result", 103, bus.result_o, 32'hFFFFFFFD);
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.halt_i  = 1'b1;

        // Reset mid-operation drops the work and the cached entry.
        @(negedge clk);
        run_op(DIV_DIVU, 1'b0, 32'd50, 32'd3, 32'd16, 32, 104);
        bus.operator_i        = DIV_DIVU;
        bus.data_ind_timing_i = 1'b0;
        bus.op_a_i            = 32'd90;
        bus.op_b_i            = 32'd9;
        bus.valid_i           = 1'b1;
        bus.halt_i            = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        repeat (2) begin
            #1;
            if (bus.valid_o || bus.ready_o || (bus.result_o != 32'd0)) bad = 1'b1;
            @(negedge clk);
        end
        check("midop_reset_outputs", 105, {31'd0, bad}, 32'd0);
        bus.valid_i = 1'b0;
        bus.halt_i  = 1'b1;
        rst         = 1'b0;
        @(negedge clk);
        check("post_reset_valid", 105, {31'd0, bus.valid_o}, 32'd0);
        run_op(DIV_REMU, 1'b0, 32'd50, 32'd3, 32'd2, 32, 106);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
